// File: rtl/psx_controller_responder.sv
// PSX digital-pad target: answers the 5-byte poll (FF, ID, 5A, buttons lo, buttons hi)
// over the host-driven att/psx_clk/cmd link, with a delayed active-low ack per byte.
module psx_controller_responder #(
   parameter logic [7:0]  CTRL_ID    = 8'h41,
   parameter int unsigned ACK_DELAY  = 4,
   parameter int unsigned ACK_CYCLES = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        att,
   input  logic        psx_clk,
   input  logic        cmd,
   input  logic [15:0] buttons,
   output logic        dat,
   output logic        ack,
   output logic [7:0]  cmd_byte,
   output logic        cmd_valid,
   output logic        poll_done
);

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      ACK_WAIT,
      ACK_PULSE,
      IGNORE
   } state_t;

   state_t      state, state_n;
   logic [2:0]  att_sr, clk_sr;
   logic [1:0]  cmd_sr;
   logic        att_fall, att_rise, clk_fall, clk_rise, cmd_s;

   logic [2:0]  bit_cnt, bit_n;
   logic [2:0]  idx, idx_n;
   logic [6:0]  sh, sh_n;
   logic [7:0]  cnt, cnt_n;
   logic [15:0] btn, btn_n;
   logic        dat_n, cmd_valid_n, poll_done_n;
   logic [7:0]  cmd_byte_n;
   logic [7:0]  tx_byte, rx_byte;

   // att synchroniser resets low so a host already holding att low at reset
   // release is not mistaken for a fresh falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         att_sr <= '0;
         clk_sr <= '1;
         cmd_sr <= '1;
      end else begin
         att_sr <= {att_sr[1:0], att};
         clk_sr <= {clk_sr[1:0], psx_clk};
         cmd_sr <= {cmd_sr[0], cmd};
      end
   end

   assign att_fall = att_sr[2] & ~att_sr[1];
   assign att_rise = ~att_sr[2] & att_sr[1];
   assign clk_fall = clk_sr[2] & ~clk_sr[1];
   assign clk_rise = ~clk_sr[2] & clk_sr[1];
   assign cmd_s    = cmd_sr[1];
   assign rx_byte  = {cmd_s, sh};
   assign ack      = (state != ACK_PULSE);

   always_comb begin
      case (idx)
         3'd0:    tx_byte = 8'hFF;
         3'd1:    tx_byte = CTRL_ID;
         3'd2:    tx_byte = 8'h5A;
         3'd3:    tx_byte = btn[7:0];
         3'd4:    tx_byte = btn[15:8];
         default: tx_byte = 8'hFF;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         idx       <= '0;
         sh        <= '0;
         cnt       <= '0;
         btn       <= '1;
         dat       <= 1'b1;
         cmd_byte  <= '0;
         cmd_valid <= 1'b0;
         poll_done <= 1'b0;
      end else begin
         state     <= state_n;
         bit_cnt   <= bit_n;
         idx       <= idx_n;
         sh        <= sh_n;
         cnt       <= cnt_n;
         btn       <= btn_n;
         dat       <= dat_n;
         cmd_byte  <= cmd_byte_n;
         cmd_valid <= cmd_valid_n;
         poll_done <= poll_done_n;
      end
   end

   always_comb begin
      state_n     = state;
      bit_n       = bit_cnt;
      idx_n       = idx;
      sh_n        = sh;
      cnt_n       = cnt;
      btn_n       = btn;
      dat_n       = dat;
      cmd_byte_n  = cmd_byte;
      cmd_valid_n = 1'b0;
      poll_done_n = 1'b0;

      if (att_rise) begin
         state_n = IDLE;
         dat_n   = 1'b1;
         bit_n   = '0;
         cnt_n   = '0;
      end else begin
         case (state)
            IDLE: begin
               dat_n = 1'b1;
               if (att_fall) begin
                  btn_n   = buttons;
                  idx_n   = '0;
                  bit_n   = '0;
                  state_n = SHIFT;
               end
            end

            SHIFT: begin
               if (clk_fall)
                  dat_n = tx_byte[bit_cnt];
               if (clk_rise) begin
                  sh_n  = rx_byte[7:1];
                  bit_n = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     cmd_byte_n  = rx_byte;
                     cmd_valid_n = 1'b1;
                     idx_n       = (idx == 3'd4) ? idx : idx + 3'd1;
                     if ((idx == 3'd0 && rx_byte != 8'h01) ||
                         (idx == 3'd1 && rx_byte != 8'h42)) begin
                        state_n = IGNORE;
                        dat_n   = 1'b1;
                     end else if (idx == 3'd4) begin
                        poll_done_n = 1'b1;
                        state_n     = IGNORE;
                        dat_n       = 1'b1;
                     end else begin
                        state_n = ACK_WAIT;
                        cnt_n   = 8'd1;
                     end
                  end
               end
            end

            // A host that clocks the next byte early cuts the ack short;
            // that falling edge is consumed here as bit 0 of the new byte.
            ACK_WAIT, ACK_PULSE: begin
               if (clk_fall) begin
                  state_n = SHIFT;
                  cnt_n   = '0;
                  dat_n   = tx_byte[bit_cnt];
               end else if (state == ACK_WAIT) begin
                  if (cnt == 8'(ACK_DELAY)) begin
                     state_n = ACK_PULSE;
                     cnt_n   = 8'd1;
                  end else begin
                     cnt_n = cnt + 8'd1;
                  end
               end else begin
                  if (cnt == 8'(ACK_CYCLES)) begin
                     state_n = SHIFT;
                     cnt_n   = '0;
                  end else begin
                     cnt_n = cnt + 8'd1;
                  end
               end
            end

            IGNORE: begin
               dat_n = 1'b1;
            end

            default: begin
               state_n = IDLE;
               dat_n   = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_psx_controller_responder.sv
// Directed bench for psx_controller_responder: emulates a PSX host at 1/16 of clk.
`timescale 1ns/1ps
module tb_psx_controller_responder;

   localparam int unsigned ACK_DELAY  = 4;
   localparam int unsigned ACK_CYCLES = 6;
   localparam int          ACK_FIRST  = ACK_DELAY + 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        att = 1'b1;
   logic        psx_clk = 1'b1;
   logic        cmd = 1'b1;
   logic [15:0] buttons = 16'hFFFF;
   logic        dat, ack, cmd_valid, poll_done;
   logic [7:0]  cmd_byte;

   int checks = 0;
   int errors = 0;
   int ack_lo, ack_first, tick_cnt, nvalid, npoll;
   logic [7:0] last_cmd;
   logic [7:0] rx;

   psx_controller_responder #(
      .CTRL_ID   (8'h41),
      .ACK_DELAY (ACK_DELAY),
      .ACK_CYCLES(ACK_CYCLES)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .att      (att),
      .psx_clk  (psx_clk),
      .cmd      (cmd),
      .buttons  (buttons),
      .dat      (dat),
      .ack      (ack),
      .cmd_byte (cmd_byte),
      .cmd_valid(cmd_valid),
      .poll_done(poll_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        start;
      logic [15:0] btn;
      logic [7:0]  c;
      logic [7:0]  exp_dat;
      logic        exp_ack;
      int          exp_nvalid;
      int          exp_npoll;
      logic        stop;
   } vec_t;

   vec_t vt[16];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      tick_cnt++;
      if (!ack) begin
         ack_lo++;
         if (ack_first == 0) ack_first = tick_cnt;
      end
      if (cmd_valid) begin
         nvalid++;
         last_cmd = cmd_byte;
      end
      if (poll_done) npoll++;
   endtask

   task automatic clear_counts();
      ack_lo = 0; ack_first = 0; tick_cnt = 0; nvalid = 0; npoll = 0; last_cmd = 8'h00;
   endtask

   task automatic send_bits(input logic [7:0] c, input int nbits, output logic [7:0] r);
      r = 8'hFF;
      for (int b = 0; b < nbits; b++) begin
         psx_clk = 1'b0;
         cmd = c[b];
         repeat (8) tick();
         r[b] = dat;
         psx_clk = 1'b1;
         if (b == 7) tick_cnt = 0;
         repeat (8) tick();
      end
   endtask

   task automatic xfer(input logic [7:0] c, output logic [7:0] r);
      clear_counts();
      send_bits(c, 8, r);
      repeat (16) tick();
   endtask

   task automatic frame_start();
      att = 1'b0;
      repeat (8) tick();
   endtask

   task automatic frame_end(input string tag);
      att = 1'b1;
      repeat (8) tick();
      chk({tag, "_end_dat"}, int'(dat), 1);
      chk({tag, "_end_ack"}, int'(ack), 1);
   endtask

   initial begin
      clear_counts();
      vt[0]  = '{1'b1, 16'hFFFE, 8'h01, 8'hFF, 1'b1, 1, 0, 1'b0};
      vt[1]  = '{1'b0, 16'hFFFE, 8'h42, 8'h41, 1'b1, 1, 0, 1'b0};
      vt[2]  = '{1'b0, 16'hFFFE, 8'h00, 8'h5A, 1'b1, 1, 0, 1'b0};
      vt[3]  = '{1'b0, 16'hFFFE, 8'h00, 8'hFE, 1'b1, 1, 0, 1'b0};
      vt[4]  = '{1'b0, 16'hFFFE, 8'h00, 8'hFF, 1'b0, 1, 1, 1'b1};
      vt[5]  = '{1'b1, 16'hFFFE, 8'h81, 8'hFF, 1'b0, 1, 0, 1'b0};
      vt[6]  = '{1'b0, 16'hFFFE, 8'h42, 8'hFF, 1'b0, 0, 0, 1'b0};
      vt[7]  = '{1'b0, 16'hFFFE, 8'h00, 8'hFF, 1'b0, 0, 0, 1'b1};
      vt[8]  = '{1'b1, 16'hA55A, 8'h01, 8'hFF, 1'b1, 1, 0, 1'b0};
      vt[9]  = '{1'b0, 16'hA55A, 8'h42, 8'h41, 1'b1, 1, 0, 1'b0};
      vt[10] = '{1'b0, 16'hA55A, 8'h00, 8'h5A, 1'b1, 1, 0, 1'b0};
      vt[11] = '{1'b0, 16'hA55A, 8'h00, 8'h5A, 1'b1, 1, 0, 1'b0};
      vt[12] = '{1'b0, 16'hA55A, 8'h00, 8'hA5, 1'b0, 1, 1, 1'b1};
      vt[13] = '{1'b1, 16'hFFFE, 8'h01, 8'hFF, 1'b1, 1, 0, 1'b0};
      vt[14] = '{1'b0, 16'hFFFE, 8'h43, 8'h41, 1'b0, 1, 0, 1'b0};
      vt[15] = '{1'b0, 16'hFFFE, 8'h00, 8'hFF, 1'b0, 0, 0, 1'b1};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dat", int'(dat), 1);
      chk("rst_ack", int'(ack), 1);
      chk("rst_cmd_byte", int'(cmd_byte), 0);
      chk("rst_cmd_valid", int'(cmd_valid), 0);
      chk("rst_poll_done", int'(poll_done), 0);
      rst_n = 1'b1;
      repeat (8) tick();

      for (int i = 0; i < 16; i++) begin
         if (vt[i].start) begin
            buttons = vt[i].btn;
            frame_start();
         end
         xfer(vt[i].c, rx);
         chk($sformatf("v%0d_dat", i), int'(rx), int'(vt[i].exp_dat));
         if (vt[i].exp_ack) begin
            chk($sformatf("v%0d_ack_len", i), ack_lo, ACK_CYCLES);
            chk($sformatf("v%0d_ack_delay", i), ack_first, ACK_FIRST);
         end else begin
            chk($sformatf("v%0d_no_ack", i), ack_lo, 0);
         end
         chk($sformatf("v%0d_nvalid", i), nvalid, vt[i].exp_nvalid);
         if (vt[i].exp_nvalid != 0)
            chk($sformatf("v%0d_cmd_byte", i), int'(last_cmd), int'(vt[i].c));
         chk($sformatf("v%0d_poll_done", i), npoll, vt[i].exp_npoll);
         if (vt[i].stop) frame_end($sformatf("v%0d", i));
      end

      // att raised after 3 bits of byte 2
      frame_start();
      xfer(8'h01, rx);
      xfer(8'h42, rx);
      clear_counts();
      send_bits(8'h00, 3, rx);
      chk("part_dat_before", int'(dat), 0);
      att = 1'b1;
      repeat (4) tick();
      chk("part_dat", int'(dat), 1);
      chk("part_ack", int'(ack), 1);
      chk("part_nvalid", nvalid, 0);
      repeat (8) tick();
      frame_start();
      xfer(8'h01, rx);
      chk("part_restart_b0", int'(rx), 8'hFF);
      chk("part_restart_b0_cmd", int'(last_cmd), 8'h01);
      xfer(8'h42, rx);
      chk("part_restart_b1", int'(rx), 8'h41);
      frame_end("part");

      // buttons change after att fall are not reflected
      buttons = 16'hFFFE;
      frame_start();
      buttons = 16'h0000;
      xfer(8'h01, rx);
      xfer(8'h42, rx);
      xfer(8'h00, rx);
      xfer(8'h00, rx);
      chk("latch_b3", int'(rx), 8'hFE);
      xfer(8'h00, rx);
      chk("latch_b4", int'(rx), 8'hFF);
      frame_end("latch");
      frame_start();
      xfer(8'h01, rx);
      xfer(8'h42, rx);
      xfer(8'h00, rx);
      xfer(8'h00, rx);
      chk("latch2_b3", int'(rx), 8'h00);
      xfer(8'h00, rx);
      chk("latch2_b4", int'(rx), 8'h00);
      chk("latch2_poll", npoll, 1);
      frame_end("latch2");

      // reset pulsed while ack is low after byte 1
      frame_start();
      xfer(8'h01, rx);
      clear_counts();
      send_bits(8'h42, 8, rx);
      for (int k = 0; k < 30 && ack_lo == 0; k++) tick();
      chk("rst_mid_ack_seen", int'(ack_lo != 0), 1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_ack", int'(ack), 1);
      chk("rst_mid_dat", int'(dat), 1);
      chk("rst_mid_cmd_byte", int'(cmd_byte), 0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (4) tick();
      xfer(8'h01, rx);
      chk("post_rst_dat", int'(rx), 8'hFF);
      chk("post_rst_no_ack", ack_lo, 0);
      chk("post_rst_nvalid", nvalid, 0);
      att = 1'b1;
      repeat (8) tick();
      frame_start();
      xfer(8'h01, rx);
      chk("post_rst_poll_b0", int'(rx), 8'hFF);
      chk("post_rst_poll_ack", ack_lo, ACK_CYCLES);
      chk("post_rst_poll_valid", nvalid, 1);
      xfer(8'h42, rx);
      chk("post_rst_poll_b1", int'(rx), 8'h41);
      frame_end("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
